// File: rtl/adc_code_avg.sv
// Windowed averager for the 5-bit flash-ADC code: 2^LOG2_N samples per window,
// rounded average plus min/max/clip, presented through a one-entry valid/ready buffer.
module adc_code_avg #(
  parameter int unsigned LOG2_N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [4:0] code_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_avg,
  output logic [4:0] out_min,
  output logic [4:0] out_max,
  output logic       out_clip,
  output logic       ovf
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned AW = 5 + LOG2_N;
  localparam int unsigned CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [AW-1:0] Half    = AW'(N / 2);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e state_q, state_d;

  logic          s1_vld_q;
  logic [4:0]    s1_code_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    min_q, min_d;
  logic [4:0]    max_q, max_d;
  logic          clip_q, clip_d;

  logic          out_valid_q, out_valid_d;
  logic [4:0]    out_avg_q, out_min_q, out_max_q;
  logic          out_clip_q;
  logic          ovf_q, ovf_d;

  logic          first;
  logic          last;
  logic          complete;
  logic          load;
  logic          sample_clip;
  logic [AW-1:0] fold_acc;
  logic [AW-1:0] rounded;
  logic [4:0]    fold_min, fold_max;
  logic          fold_clip;
  logic [4:0]    avg;

  // Fold the staged sample into the running window; a fresh window starts from it alone.
  always_comb begin
    first       = (state_q == StIdle);
    sample_clip = (s1_code_q == 5'd0) || (s1_code_q == 5'd31);
    fold_acc    = first ? AW'(s1_code_q) : acc_q + AW'(s1_code_q);
    fold_min    = (first || (s1_code_q < min_q)) ? s1_code_q : min_q;
    fold_max    = (first || (s1_code_q > max_q)) ? s1_code_q : max_q;
    fold_clip   = sample_clip || (!first && clip_q);
    last        = first ? (N == 1) : (cnt_q == CntLast);
    complete    = s1_vld_q && last;
    // Sum never exceeds 31N + N/2, so the top five bits hold the rounded average.
    rounded     = fold_acc + Half;
    avg         = rounded[LOG2_N +: 5];

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    clip_d  = clip_q;
    if (s1_vld_q) begin
      acc_d  = fold_acc;
      min_d  = fold_min;
      max_d  = fold_max;
      clip_d = fold_clip;
      if (last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StAcc;
        cnt_d   = first ? CW'(1) : cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    load        = complete && (!out_valid_q || out_ready);
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (complete && out_valid_q && !out_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      clip_q    <= 1'b0;
    end else if (clr) begin
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      clip_q    <= 1'b0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= code_in;
      end
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
      clip_q  <= clip_d;
    end
  end

  // Result data holds across clr; only the valid and overflow flags drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_avg_q   <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      out_clip_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      if (load) begin
        out_avg_q  <= avg;
        out_min_q  <= fold_min;
        out_max_q  <= fold_max;
        out_clip_q <= fold_clip;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_avg   = out_avg_q;
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;
  assign out_clip  = out_clip_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adc_code_avg.sv
// Bench for adc_code_avg: LOG2_N=2 and LOG2_N=0 instances, scoreboard of expected
// window results popped whenever a result is handed off.
module tb_adc_code_avg;

  typedef struct packed {
    logic [4:0] avg;
    logic [4:0] mn;
    logic [4:0] mx;
    logic       clip;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr2 = 1'b0, v2 = 1'b0, r2 = 1'b0;
  logic [4:0] c2 = '0;
  logic       ov2, clip2, ovf2;
  logic [4:0] avg2, min2, max2;
  logic       clr0 = 1'b0, v0 = 1'b0, r0 = 1'b0;
  logic [4:0] c0 = '0;
  logic       ov0, clip0, ovf0;
  logic [4:0] avg0, min0, max0;

  int   errors = 0;
  int   checks = 0;
  res_t q2[$];
  res_t q0[$];
  res_t exp2, exp0;

  always #5 clk = ~clk;

  adc_code_avg #(.LOG2_N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .in_valid(v2), .code_in(c2),
    .out_valid(ov2), .out_ready(r2), .out_avg(avg2), .out_min(min2), .out_max(max2),
    .out_clip(clip2), .ovf(ovf2)
  );

  adc_code_avg #(.LOG2_N(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .in_valid(v0), .code_in(c0),
    .out_valid(ov0), .out_ready(r0), .out_avg(avg0), .out_min(min0), .out_max(max0),
    .out_clip(clip0), .ovf(ovf0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t win4(input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [4:0] d);
    logic [4:0] v[4];
    int         s;
    res_t       r;
    v = '{a, b, c, d};
    s = 0;
    r.mn = 5'd31;
    r.mx = 5'd0;
    r.clip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = s + int'(v[i]);
      if (v[i] < r.mn) r.mn = v[i];
      if (v[i] > r.mx) r.mx = v[i];
      if (v[i] == 5'd0 || v[i] == 5'd31) r.clip = 1'b1;
    end
    r.avg = 5'((s + 2) / 4);
    return r;
  endfunction

  // Handoff monitors: a result is consumed on the edge after a negedge showing valid&&ready.
  always @(negedge clk) begin
    if (rst_n && ov2 && r2) begin
      if (q2.size() == 0) begin
        chk("unexpected_result2", 32'd1, 32'd0);
      end else begin
        exp2 = q2.pop_front();
        chk("result2", {16'd0, avg2, min2, max2, clip2}, {16'd0, exp2});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov0 && r0) begin
      if (q0.size() == 0) begin
        chk("unexpected_result0", 32'd1, 32'd0);
      end else begin
        exp0 = q0.pop_front();
        chk("result0", {16'd0, avg0, min0, max0, clip0}, {16'd0, exp0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [4:0] c);
    v2 = 1'b1;
    c2 = c;
    tick();
    v2 = 1'b0;
  endtask

  task automatic win2(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                      input logic [4:0] d, input int maxgap, input bit expect_load);
    logic [4:0] v[4];
    v = '{a, b, c, d};
    if (expect_load) q2.push_back(win4(a, b, c, d));
    for (int i = 0; i < 4; i++) begin
      send2(v[i]);
      if (i < 3) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  initial begin
    #7;
    chk("reset_outputs2", {20'd0, ov2, avg2, min2, max2, clip2, ovf2}, 32'd0);
    chk("reset_outputs0", {20'd0, ov0, avg0, min0, max0, clip0, ovf0}, 32'd0);
    #8 rst_n = 1'b1;
    tick();

    // Basic window and latency
    r2 = 1'b1;
    win2(5'd3, 5'd4, 5'd4, 5'd5, 0, 1'b1);
    @(negedge clk) chk("latency_early", {31'd0, ov2}, 32'd0);
    @(negedge clk) chk("latency_valid", {31'd0, ov2}, 32'd1);
    chk("basic_avg", {27'd0, avg2}, 32'd4);
    @(negedge clk) chk("valid_pulse", {31'd0, ov2}, 32'd0);

    // Back-to-back rounding and clip windows
    win2(5'd1, 5'd2, 5'd2, 5'd2, 0, 1'b1);
    win2(5'd31, 5'd31, 5'd31, 5'd31, 0, 1'b1);
    repeat (3) tick();
    chk("clip_window", {31'd0, clip2}, 32'd1);

    // Random input gaps
    win2(5'd3, 5'd4, 5'd4, 5'd5, 3, 1'b1);
    repeat (4) tick();

    // Backpressure: second window dropped
    r2 = 1'b0;
    win2(5'd10, 5'd12, 5'd14, 5'd16, 0, 1'b1);
    win2(5'd0, 5'd5, 5'd6, 5'd7, 0, 1'b0);
    @(negedge clk) chk("ovf_before_drop", {31'd0, ovf2}, 32'd0);
    @(negedge clk) chk("ovf_after_drop", {31'd0, ovf2}, 32'd1);
    chk("held_valid", {31'd0, ov2}, 32'd1);
    chk("held_data", {17'd0, avg2, min2, max2}, {17'd0, 5'd13, 5'd10, 5'd16});
    tick();
    r2 = 1'b1;
    tick();
    r2 = 1'b0;
    @(negedge clk) chk("valid_after_take", {31'd0, ov2}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf2}, 32'd1);
    tick();
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    @(negedge clk) chk("ovf_cleared", {31'd0, ovf2}, 32'd0);

    // Handshake on the exact completion edge
    tick();
    win2(5'd10, 5'd12, 5'd14, 5'd16, 0, 1'b1);
    repeat (2) tick();
    win2(5'd20, 5'd20, 5'd21, 5'd21, 0, 1'b1);
    r2 = 1'b1;
    tick();
    r2 = 1'b0;
    @(negedge clk) chk("reload_valid", {31'd0, ov2}, 32'd1);
    chk("reload_ovf", {31'd0, ovf2}, 32'd0);
    chk("reload_avg", {27'd0, avg2}, 32'd21);
    tick();
    r2 = 1'b1;
    tick();

    // Asynchronous reset mid-window
    send2(5'd31);
    send2(5'd31);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {20'd0, ov2, avg2, min2, max2, clip2, ovf2}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    win2(5'd8, 5'd9, 5'd10, 5'd11, 0, 1'b1);
    repeat (3) tick();

    // Synchronous clear mid-window, with a sample presented on the clear edge
    send2(5'd31);
    send2(5'd31);
    clr2 = 1'b1;
    v2 = 1'b1;
    c2 = 5'd31;
    tick();
    clr2 = 1'b0;
    v2 = 1'b0;
    win2(5'd8, 5'd9, 5'd10, 5'd11, 0, 1'b1);
    repeat (3) tick();

    // LOG2_N=0 sweep
    r0 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      q0.push_back({5'(i), 5'(i), 5'(i), (i == 0 || i == 31)});
      v0 = 1'b1;
      c0 = 5'(i);
      tick();
    end
    v0 = 1'b0;
    repeat (4) tick();

    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_code_avg.md
# adc_code_avg

Windowed averager and one-entry output buffer for the 5-bit binary flash-ADC code. Sits directly downstream of the thermometer-decoder/priority-encoder path. It registers each strobed code and accumulates 2^LOG2_N consecutive samples. Per window it produces a rounded average, the window minimum and maximum, and a clip flag, presented on a valid/ready handshake to the SoC side.

## Interface
- LOG2_N, default 2: log2 of samples per window; legal range 0..4 (window size 1..16).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear; highest priority after reset.
- in_valid  in  1  code_in is a sample this cycle; always accepted (no in_ready).
- code_in  in  5  binary ADC code, 0..31.
- out_valid  out  1  result buffer holds an unconsumed result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready at a clock edge.
- out_avg  out  5  rounded window average.
- out_min  out  5  smallest sample in window.
- out_max  out  5  largest sample in window.
- out_clip  out  1  some sample in window was 0 or 31.
- ovf  out  1  sticky: a completed result was dropped because the buffer was full.

## Operation
- Stage 1 (capture): on an edge with in_valid=1, s1_code <= code_in and s1_vld <= 1; otherwise s1_vld <= 0.
- Stage 2 (accumulate) acts on s1_vld=1. Registers:
  - acc, width 5+LOG2_N.
  - cnt, width max(LOG2_N,1).
  - run_min, run_max, run_clip.
- FSM, 2 states:
  - IDLE: no samples in the current window.
  - ACC: 1..N-1 samples held.
- IDLE with s1_vld: acc <= s1_code, run_min = run_max = s1_code, run_clip = (s1_code==0 || s1_code==31), cnt <= 1. Next state is ACC, or stays IDLE with a result issued if N=1.
- ACC with s1_vld: the sample folds into acc, min, max and clip.
  - If cnt==N-1, the window completes, the state returns to IDLE, and cnt <= 0.
  - Otherwise cnt increments.
- Gaps (s1_vld=0) do not advance the window or change the state.
- Result on window completion, computed from the folded values including the final sample:
  - sum = acc + s1_code.
  - avg = (sum + 2^(LOG2_N-1)) >> LOG2_N for LOG2_N>0; avg = sum for LOG2_N=0.
  - Rounding is round-half-up. The maximum is (31N + N/2)>>LOG2_N = 31, so the result never exceeds 5 bits and needs no saturation.
- Output buffer, one entry:
  - Completion with out_valid=0, or with out_valid && out_ready on the same edge: load out_avg, out_min, out_max, out_clip and set out_valid=1.
  - Completion with out_valid && !out_ready: the new result is discarded, the buffer is unchanged, and ovf <= 1.
  - Handshake without completion: out_valid <= 0. The data outputs hold their last values.
- clr=1 on an edge:
  - s1_vld, acc, cnt, run_* and the state return to reset values (IDLE), and out_valid <= 0, ovf <= 0.
  - The sample presented that cycle is not captured, and any in-flight sample is lost.
- rst_n=0 at any time, including mid-window or while out_valid=1: all state is cleared immediately with no handshake.

## Timing
- Reset values: out_valid=0, out_avg=0, out_min=0, out_max=0, out_clip=0, ovf=0, FSM=IDLE, cnt=0, acc=0, s1_vld=0.
- Latency: the Nth sample taken at edge E sets out_valid high after edge E+1, with out_* valid in the same cycle.
- Throughput: one sample per cycle sustained. Back-to-back windows need no idle cycles, so consecutive results may be N cycles apart.
- out_valid and out_* are stable while out_valid && !out_ready.
- ovf changes only on a dropped completion, clr, or reset.
- The outputs are driven directly from registers; there is no combinational path from inputs to outputs.

## Test plan
- LOG2_N=2, samples 3,4,4,5 on consecutive cycles, out_ready=1 → out_valid pulses 1 cycle, two edges after the 4th sample; out_avg=4 (16+2>>2), out_min=3, out_max=5, out_clip=0.
- LOG2_N=2, rounding and clip:
  - Samples 1,2,2,2 → out_avg=2 (9>>2), out_clip=0.
  - Then samples 31,31,31,31 → out_avg=31, out_min=31, out_max=31, out_clip=1.
  - Windows run back-to-back with no gap.
- LOG2_N=2, samples arrive with random in_valid gaps → result identical to the gapless case; cnt advances only on valid samples.
- Backpressure:
  - out_ready=0, then two full windows complete → first result held stable, second dropped, ovf=1.
  - Then out_ready=1 for one cycle → out_valid=0.
  - Then clr → ovf=0.
  - Repeat with out_ready=1 on the exact completion edge → new result loaded, out_valid stays 1, ovf stays 0.
- Reset and clear mid-window:
  - 2 samples, then rst_n=0 asynchronously mid-cycle → all outputs 0 immediately; the next 4 samples form a fresh window whose average matches those 4 only.
  - Same sequence with clr instead → same result.
- LOG2_N=0: each sample 0..31 → out_avg=out_min=out_max=sample two edges later; out_clip=1 only for 0 and 31.
